mag_sched: RTL
==============

# mag_sched

Two-requester scheduler and sequencer for the shared cartesian-to-polar magnitude datapath. It computes r = sqrt(x² + y²) as a multi-cycle operation. It arbitrates round-robin between requesters A and B, captures the winner's operands, and squares and sums them in one cycle. It then extracts the square root one bit per cycle and holds the tagged result until the consumer accepts it.

## Interface
- No parameters. Widths are fixed: 8-bit operands, 17-bit sum of squares, 9-bit result.

- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  global enable; when low the block freezes.
- a_valid  input  1  requester A has operands.
- a_ready  output  1  A's request is accepted this cycle.
- a_x, a_y  input  8 each  A's operands, unsigned.
- b_valid, b_ready, b_x, b_y  requester B; same as A.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_r  output  9  magnitude, unsigned.
- res_id  output  1  source of the result: 0 = A, 1 = B.

## Operation
- FSM states: IDLE, SQ, ROOT, DONE. Reset values:
  - state = IDLE, prio = 0
  - res_valid = 0, res_r = 0, res_id = 0
  - all internal registers = 0
- a_ready and b_ready are combinational. Both are 0 while rst_n = 0, ena = 0, or state ≠ IDLE.
- Arbitration in IDLE with ena = 1:
  - Exactly one valid requester: that requester is granted.
  - Both valid: the requester named by prio is granted (prio = 0 → A).
  - At most one ready is ever high.
- Accept edge: operands and id are captured, prio is set to the non-granted id, state → SQ. prio changes only on an accept.
- SQ, one edge: s = x·x + y·y (17-bit, no overflow, max 130050). Initialise root = 0, remainder = 0, bit counter = 8. State → ROOT.
- ROOT, 9 edges: non-restoring/digit-by-digit integer square root, MSB-first, one result bit per edge. After the counter-0 edge: res_r = floor(sqrt(s)), res_valid = 1, state → DONE.
- DONE: res_r and res_id are held stable while res_valid = 1.
  - On the edge where res_valid & res_ready & ena: res_valid → 0, state → IDLE.
  - res_r and res_id keep their last value after that edge.
- ena = 0: no state, counter, prio or output register changes. Handshakes do not complete. res_valid holds its value.
- Requester inputs are sampled only on the accept edge. Later changes do not affect the computation in flight.
- Reset asserted mid-operation: immediate return to the reset values. The in-flight result is discarded and nothing is output for it.

## Timing
- Accept at edge k (IDLE → SQ).
  - k+1: SQ → ROOT.
  - k+2 … k+10: root bits.
  - res_valid is high after edge k+10.
- Latency: 10 cycles from accept to res_valid with ena held high. Each ena-low cycle adds one cycle.
- Result handshake at edge m: the earliest next accept is edge m+1.
- Peak throughput: one result per 12 cycles with res_ready held high.
- A request held valid with no consumer backpressure waits at most one full operation of the other requester (no starvation).

## Configuration
- MAG_SCHED_ROUND_EN
  - Defined: on the final ROOT edge, if (s − root²) > root, res_r = root + 1; otherwise res_r = root. This rounds to nearest, ties impossible for integers. Maximum output is 361, which fits 9 bits. Latency is unchanged.
  - Undefined: res_r = floor(sqrt(s)).

## Test plan
- Single request: A sends x=3, y=4, res_ready=1 → res_valid after edge k+10, res_r=5, res_id=0. Same result with or without rounding.
- Extremes: x=255, y=255 → res_r=360 without MAG_SCHED_ROUND_EN, 361 with it. Then x=0, y=0 → 0. Then x=2, y=3 → 3 without rounding, 4 with rounding.
- Contention: A (1,1) and B (5,5) both valid from reset and held → A granted first (res_r=1, id=0), then B (res_r=7, id=1). Re-assert both → A next. b_ready and a_ready are never high together.
- Backpressure: res_ready=0 for 20 cycles after res_valid → res_r/res_id stable, a_ready/b_ready stay 0. Raise res_ready → valid drops next edge, a_ready allowed the following cycle.
- ena gating: drop ena for 3 cycles during ROOT → res_valid appears 3 cycles late with a correct value. ena=0 in DONE with res_ready=1 → result not consumed.
- Async reset: assert rst_n low mid-ROOT → res_valid=0, res_r=0 immediately. After release, a new request (3,4) → 5, with prio back at A.

Source files
------------

// File: rtl/mag_sched.sv
// mag_sched
// Two-requester scheduler and sequencer for the shared magnitude datapath.
// Computes r = sqrt(x*x + y*y) over ten cycles. It arbitrates round-robin
// between requesters A and B and squares and sums the winner's operands in
// one cycle. It then extracts the integer square root MSB-first, one bit per
// cycle, and holds the tagged result until the consumer takes it.
//
// Ports
//   clk                 clock, rising edge
//   rst_n               asynchronous active-low reset
//   ena                 global enable; low freezes every register
//   a_valid / a_ready   requester A handshake (a_ready is combinational)
//   a_x, a_y            requester A operands, 8-bit unsigned
//   b_valid / b_ready   requester B handshake (b_ready is combinational)
//   b_x, b_y            requester B operands, 8-bit unsigned
//   res_valid/res_ready result handshake
//   res_r               9-bit magnitude
//   res_id              source of the result (0 = A, 1 = B)
//
// Build option
//   MAG_SCHED_ROUND_EN  when defined, the result is rounded to nearest
//                       instead of truncated (floor).

module mag_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] a_x,
  input  logic [7:0] a_y,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [7:0] b_x,
  input  logic [7:0] b_y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [8:0] res_r,
  output logic       res_id
);

  typedef enum logic [1:0] {IDLE, SQ, ROOT, DONE} state_e;

  state_e      state_q, state_d;
  logic        prio_q;
  logic [7:0]  opX_q, opY_q;
  logic        id_q;
  logic [16:0] sumSq_q;
  logic [8:0]  root_q;
  logic [9:0]  rem_q;
  logic [3:0]  cnt_q;
  logic        resValid_q;
  logic [8:0]  resR_q;
  logic        resId_q;

  logic        grantA, grantB;
  logic        accept;
  logic [17:0] sumExt;
  logic [1:0]  pair;
  logic [11:0] remShift, trial;
  logic [9:0]  remNext;
  logic [8:0]  rootNext;
  logic [8:0]  resFinal;

  // State register; ena low freezes the sequencer in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DONE always has res_valid high, so res_ready alone
  // completes the result handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (a_valid || b_valid) state_d = SQ;
      SQ:   state_d = ROOT;
      ROOT: if (cnt_q == 4'd0) state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: round-robin grant. prio picks the winner only on a tie.
  // rst_n is folded in so no ready leaks out while reset is held.
  always_comb begin
    grantA  = a_valid && (!b_valid || !prio_q);
    grantB  = b_valid && (!a_valid ||  prio_q);
    a_ready = rst_n && ena && (state_q == IDLE) && grantA;
    b_ready = rst_n && ena && (state_q == IDLE) && grantB;
    accept  = a_ready || b_ready;
  end

  // One digit-by-digit square-root step. The next two bits of the sum are
  // appended to the remainder, and the trial value 4*root+1 is subtracted
  // when it fits. The remainder stays below 2*root+1, so 10 bits hold it.
  always_comb begin
    sumExt   = {1'b0, sumSq_q};
    pair     = sumExt[{cnt_q, 1'b0} +: 2];
    remShift = {rem_q, pair};
    trial    = {1'b0, root_q, 2'b01};
    if (remShift >= trial) begin
      remNext  = 10'(remShift - trial);
      rootNext = {root_q[7:0], 1'b1};
    end else begin
      remNext  = remShift[9:0];
      rootNext = {root_q[7:0], 1'b0};
    end
`ifdef MAG_SCHED_ROUND_EN
    // s - root^2 is the final remainder. Exceeding root means s lies past
    // (root + 0.5)^2, so round up. Ties cannot occur for integers.
    resFinal = (remNext > {1'b0, rootNext}) ? rootNext + 9'd1 : rootNext;
`else
    resFinal = rootNext;
`endif
  end

  // Datapath and result registers, all frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      opX_q      <= '0;
      opY_q      <= '0;
      id_q       <= 1'b0;
      sumSq_q    <= '0;
      root_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      resValid_q <= 1'b0;
      resR_q     <= '0;
      resId_q    <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opX_q  <= grantB ? b_x : a_x;
            opY_q  <= grantB ? b_y : a_y;
            id_q   <= grantB;
            prio_q <= ~grantB;
          end
        end
        SQ: begin
          sumSq_q <= 17'(opX_q) * 17'(opX_q) + 17'(opY_q) * 17'(opY_q);
          root_q  <= '0;
          rem_q   <= '0;
          cnt_q   <= 4'd8;
        end
        ROOT: begin
          root_q <= rootNext;
          rem_q  <= remNext;
          if (cnt_q == 4'd0) begin
            resR_q     <= resFinal;
            resId_q    <= id_q;
            resValid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (res_ready) resValid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign res_valid = resValid_q;
  assign res_r     = resR_q;
  assign res_id    = resId_q;

endmodule
